// File: rtl/ntt_buf_pkg.sv
// Shared definitions for the NTT reorder buffer: controller state encoding
// and the index bit-reversal used to produce the NTT input permutation.
package ntt_buf_pkg;

    localparam int MAX_LOG_N = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } bufState_t;

    // Mirrors the low logN bits of idx; shifting avoids variable bit-selects.
    function automatic int unsigned bitReverse(input int unsigned idx, input int logN);
        int unsigned result;
        int unsigned rest;
        result = 0;
        rest   = idx;
        for (int i = 0; i < MAX_LOG_N; i++) begin
            if (i < logN) begin
                result = (result << 1) | (rest & 32'd1);
                rest   = rest >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ntt_buf_ctrl.sv
// Frame sequencing for the reorder buffer: walks IDLE -> FILL -> DRAIN and
// exposes the enables that steer the counters and output register.
module ntt_buf_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic inValid_i,
    input  logic wrLast_i,
    input  logic outFire_i,
    input  logic outLast_i,
    output logic ready_o,
    output logic inReady_o,
    output logic frameStart_o,
    output logic wrEn_o,
    output logic fillDone_o,
    output logic drainEn_o
);
    import ntt_buf_pkg::*;

    bufState_t state_q;
    logic      ready_q;
    logic      inReady_q;

    // ready/inReady are kept as registered copies of the state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            inReady_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= FILL;
                        ready_q   <= 1'b0;
                        inReady_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (inValid_i && wrLast_i) begin
                        state_q   <= DRAIN;
                        inReady_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (outFire_i && outLast_i) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b1;
                    inReady_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o      = ready_q;
    assign inReady_o    = inReady_q;
    assign frameStart_o = start_i && ready_q;
    assign wrEn_o       = inValid_i && inReady_q;
    assign fillDone_o   = inValid_i && inReady_q && wrLast_i;
    assign drainEn_o    = (state_q == DRAIN);

endmodule

// File: rtl/ntt_reorder_buffer.sv
// Single-frame buffer that captures N coefficients and replays them in
// natural or bit-reversed order, chosen when the frame is started.
module ntt_reorder_buffer #(
    parameter int DATA_W = 32,
    parameter int LOG_N  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bitrev_mode,
    output logic              ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);
    import ntt_buf_pkg::*;

    localparam int N = 1 << LOG_N;
    localparam logic [LOG_N:0] FRAME_LEN = {1'b1, {LOG_N{1'b0}}};
    localparam logic [LOG_N:0] LAST_IDX  = {1'b0, {LOG_N{1'b1}}};
    localparam logic [LOG_N:0] CNT_ONE   = {{LOG_N{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [N];

    logic              mode_q,    mode_d;
    logic [LOG_N:0]    wrCnt_q,   wrCnt_d;
    logic [LOG_N:0]    rdCnt_q,   rdCnt_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic              outValid_q, outValid_d;
    logic              outLast_q,  outLast_d;

    logic              frameStart;
    logic              wrEn;
    logic              fillDone;
    logic              drainEn;
    logic              outFire;
    logic              slotFree;
    logic              rdAvail;
    logic [LOG_N-1:0]  rdAddr;

    assign outFire  = outValid_q && out_ready;
    assign slotFree = !outValid_q || out_ready;
    assign rdAvail  = (rdCnt_q < FRAME_LEN);

    ntt_buf_ctrl u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .inValid_i    (in_valid),
        .wrLast_i     (wrCnt_q == LAST_IDX),
        .outFire_i    (outFire),
        .outLast_i    (outLast_q),
        .ready_o      (ready),
        .inReady_o    (in_ready),
        .frameStart_o (frameStart),
        .wrEn_o       (wrEn),
        .fillDone_o   (fillDone),
        .drainEn_o    (drainEn)
    );

    always_comb begin
        rdAddr = rdCnt_q[LOG_N-1:0];
        if (mode_q) begin
            rdAddr = LOG_N'(bitReverse(int'(rdCnt_q[LOG_N-1:0]), LOG_N));
        end
    end

    // Output slot refills whenever it is empty or being consumed this cycle.
    always_comb begin
        mode_d     = mode_q;
        wrCnt_d    = wrCnt_q;
        rdCnt_d    = rdCnt_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;

        if (frameStart) begin
            mode_d  = bitrev_mode;
            wrCnt_d = '0;
        end else if (wrEn) begin
            wrCnt_d = wrCnt_q + CNT_ONE;
        end

        if (fillDone) begin
            rdCnt_d = '0;
        end else if (drainEn && slotFree) begin
            if (rdAvail) begin
                outData_d  = mem_q[rdAddr];
                outValid_d = 1'b1;
                outLast_d  = (rdCnt_q == LAST_IDX);
                rdCnt_d    = rdCnt_q + CNT_ONE;
            end else begin
                outValid_d = 1'b0;
                outLast_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= 1'b0;
            wrCnt_q    <= '0;
            rdCnt_q    <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            wrCnt_q    <= wrCnt_d;
            rdCnt_q    <= rdCnt_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
        end
    end

    // Frame storage is deliberately unreset; a drain only follows N fresh writes.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrCnt_q[LOG_N-1:0]] <= in_data;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;

endmodule

// File: tb/tb_ntt_reorder_buffer.sv
// Directed bench: a 4-word instance for ordering, stalls, reset and stray starts,
// plus an 8-word instance for the bit-reversed permutation.
module tb_ntt_reorder_buffer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        aStart, aMode, aReady, aInValid, aInReady, aOutValid, aOutLast, aOutReady;
    logic [31:0] aInData, aOutData;
    logic        bStart, bMode, bReady, bInValid, bInReady, bOutValid, bOutLast, bOutReady;
    logic [31:0] bInData, bOutData;

    int checkCount = 0;
    int errorCount = 0;
    int gapIdx;

    int revOrder4 [4] = '{0, 2, 1, 3};
    int revOrder8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    logic gapPattern [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    ntt_reorder_buffer #(.DATA_W(32), .LOG_N(2)) dutA (
        .clk         (clk),
        .reset       (reset),
        .start       (aStart),
        .bitrev_mode (aMode),
        .ready       (aReady),
        .in_data     (aInData),
        .in_valid    (aInValid),
        .in_ready    (aInReady),
        .out_data    (aOutData),
        .out_valid   (aOutValid),
        .out_last    (aOutLast),
        .out_ready   (aOutReady)
    );

    ntt_reorder_buffer #(.DATA_W(32), .LOG_N(3)) dutB (
        .clk         (clk),
        .reset       (reset),
        .start       (bStart),
        .bitrev_mode (bMode),
        .ready       (bReady),
        .in_data     (bInData),
        .in_valid    (bInValid),
        .in_ready    (bInReady),
        .out_data    (bOutData),
        .out_valid   (bOutValid),
        .out_last    (bOutLast),
        .out_ready   (bOutReady)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic mode);
        aStart = 1'b1;
        aMode  = mode;
        tick();
        aStart = 1'b0;
        aMode  = 1'b0;
    endtask

    // Feeds base..base+3 back-to-back; a stray start can be pulsed on one word.
    task automatic feedA(input logic [31:0] base, input int strayAt);
        for (int i = 0; i < 4; i++) begin
            aInValid = 1'b1;
            aInData  = base + 32'(i);
            if (i == strayAt) begin
                aStart = 1'b1;
                aMode  = 1'b1;
            end
            tick();
            aStart = 1'b0;
            aMode  = 1'b0;
        end
        aInValid = 1'b0;
    endtask

    task automatic drainA(input logic [31:0] base, input logic rev, input int strayAt, input string tag);
        for (int k = 0; k < 4; k++) begin
            if (k == strayAt) begin
                aStart = 1'b1;
                aMode  = ~rev;
            end
            tick();
            aStart = 1'b0;
            aMode  = 1'b0;
            checkOutput($sformatf("%s_valid%0d", tag, k), 32'(aOutValid), 32'd1);
            checkOutput($sformatf("%s_data%0d", tag, k), aOutData, base + 32'(rev ? revOrder4[k] : k));
            checkOutput($sformatf("%s_last%0d", tag, k), 32'(aOutLast), 32'(k == 3));
        end
        tick();
        checkOutput({tag, "_endvalid"}, 32'(aOutValid), 32'd0);
        checkOutput({tag, "_endready"}, 32'(aReady), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        aStart    = 1'b0;  aMode = 1'b0;  aInValid = 1'b0;  aInData = '0;  aOutReady = 1'b1;
        bStart    = 1'b0;  bMode = 1'b0;  bInValid = 1'b0;  bInData = '0;  bOutReady = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        checkOutput("rst_ready",   32'(aReady),    32'd1);
        checkOutput("rst_inready", 32'(aInReady),  32'd0);
        checkOutput("rst_valid",   32'(aOutValid), 32'd0);
        checkOutput("rst_last",    32'(aOutLast),  32'd0);
        checkOutput("rst_data",    aOutData,       32'd0);
        checkOutput("rst_b_ready", 32'(bReady),    32'd1);

        // Natural order, back-to-back, one-cycle latency after the last accept.
        applyStimulus(1'b0);
        checkOutput("t1_ready",   32'(aReady),   32'd0);
        checkOutput("t1_inready", 32'(aInReady), 32'd1);
        feedA(32'hA0, -1);
        checkOutput("t1_lat", 32'(aOutValid), 32'd0);
        drainA(32'hA0, 1'b0, -1, "t1");

        // Eight-word bit-reversed frame on the larger instance.
        bStart = 1'b1;
        bMode  = 1'b1;
        tick();
        bStart = 1'b0;
        bMode  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bInValid = 1'b1;
            bInData  = 32'(i);
            tick();
        end
        bInValid = 1'b0;
        checkOutput("t2_lat", 32'(bOutValid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("t2_valid%0d", k), 32'(bOutValid), 32'd1);
            checkOutput($sformatf("t2_data%0d", k), bOutData, 32'(revOrder8[k]));
            checkOutput($sformatf("t2_last%0d", k), 32'(bOutLast), 32'(k == 7));
        end
        tick();
        checkOutput("t2_endvalid", 32'(bOutValid), 32'd0);
        checkOutput("t2_endready", 32'(bReady),    32'd1);

        // Input gaps during fill and a three-cycle output stall on word 2.
        applyStimulus(1'b0);
        gapIdx = 0;
        for (int c = 0; c < 7; c++) begin
            aInValid = gapPattern[c];
            aInData  = gapPattern[c] ? 32'hB0 + 32'(gapIdx) : 32'hDEAD_BEEF;
            tick();
            if (gapPattern[c]) gapIdx++;
        end
        aInValid = 1'b0;
        checkOutput("t3_lat", 32'(aOutValid), 32'd0);
        tick();
        checkOutput("t3_data0", aOutData, 32'hB0);
        tick();
        checkOutput("t3_data1", aOutData, 32'hB1);
        tick();
        checkOutput("t3_data2", aOutData, 32'hB2);
        checkOutput("t3_last2", 32'(aOutLast), 32'd0);
        aOutReady = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checkOutput($sformatf("t3_hold_data%0d", s), aOutData, 32'hB2);
            checkOutput($sformatf("t3_hold_valid%0d", s), 32'(aOutValid), 32'd1);
            checkOutput($sformatf("t3_hold_last%0d", s), 32'(aOutLast), 32'd0);
        end
        aOutReady = 1'b1;
        tick();
        checkOutput("t3_data3", aOutData, 32'hB3);
        checkOutput("t3_last3", 32'(aOutLast), 32'd1);
        tick();
        checkOutput("t3_endvalid", 32'(aOutValid), 32'd0);
        checkOutput("t3_endready", 32'(aReady),    32'd1);

        // Reset after two of four inputs discards the frame.
        applyStimulus(1'b1);
        aInValid = 1'b1;
        aInData  = 32'hC0;
        tick();
        aInData  = 32'hC1;
        tick();
        aInValid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("t4_ready",   32'(aReady),    32'd1);
        checkOutput("t4_inready", 32'(aInReady),  32'd0);
        checkOutput("t4_valid",   32'(aOutValid), 32'd0);
        checkOutput("t4_data",    aOutData,       32'd0);
        reset = 1'b0;
        tick();
        applyStimulus(1'b0);
        feedA(32'hD0, -1);
        drainA(32'hD0, 1'b0, -1, "t4");

        // Stray starts in FILL and DRAIN, then an immediate restart in bit-reversed mode.
        applyStimulus(1'b0);
        feedA(32'hE0, 1);
        drainA(32'hE0, 1'b0, 1, "t5");
        applyStimulus(1'b1);
        checkOutput("t5_restart_inready", 32'(aInReady), 32'd1);
        checkOutput("t5_restart_ready",   32'(aReady),   32'd0);
        feedA(32'hF0, -1);
        drainA(32'hF0, 1'b1, -1, "t5b");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
